// File: rtl/rc4_pkg.sv
// rc4_pkg: shared phase encoding and S-memory/key widths for the RC4 sequencer
package rc4_pkg;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int KEY_W  = 24;
    typedef enum logic [2:0] {
        PH_IDLE  = 3'd0,
        PH_INIT  = 3'd1,
        PH_KSA   = 3'd2,
        PH_PRGA  = 3'd3,
        PH_DONE  = 3'd4,
        PH_ERROR = 3'd5
    } phase_t;
endpackage

// File: rtl/phase_watchdog.sv
// phase_watchdog: per-phase cycle counter flagging expiry at TIMEOUT_CYCLES-1
module phase_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 2048
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = TIMEOUT_CYCLES > 2 ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);
    logic [W-1:0] count_q, count_d;
    always_comb count_d = clear ? '0 : enable ? count_q + W'(1) : count_q;
    always_ff @(posedge clk) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end
    assign expired = enable && count_q == LAST;
endmodule

// File: rtl/rc4_sequencer.sv
// rc4_sequencer: INIT->KSA->PRGA phase sequencer with S-memory mux; RC4_SEQ_WATCHDOG_EN adds a per-phase timeout into ERROR
module rc4_sequencer
    import rc4_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 2048
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [KEY_W-1:0]  secret_key,
    output logic [KEY_W-1:0]  key_out,
    output logic              init_start,
    output logic              ksa_start,
    output logic              prga_start,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic [DATA_W-1:0] init_wdata,
    input  logic              init_wr_en,
    input  logic              init_task_on,
    input  logic              init_fin_strobe,
    input  logic [ADDR_W-1:0] ksa_addr,
    input  logic [DATA_W-1:0] ksa_wdata,
    input  logic              ksa_wr_en,
    input  logic              ksa_task_on,
    input  logic              ksa_fin_strobe,
    input  logic [ADDR_W-1:0] prga_addr,
    input  logic [DATA_W-1:0] prga_wdata,
    input  logic              prga_wr_en,
    input  logic              prga_task_on,
    input  logic              prga_fin_strobe,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wr_en,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] rdata_out,
    output logic              busy,
    output logic              done_strobe,
    output logic              err,
    output logic [2:0]        phase
);
    phase_t state_q, state_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic init_start_q, init_start_d;
    logic ksa_start_q, ksa_start_d;
    logic prga_start_q, prga_start_d;
    logic expired;
    logic unused_ok;
    always_comb begin
        state_d      = state_q;
        key_d        = key_q;
        init_start_d = 1'b0;
        ksa_start_d  = 1'b0;
        prga_start_d = 1'b0;
        case (state_q)
            PH_IDLE, PH_ERROR: if (start) begin
                state_d      = PH_INIT;
                key_d        = secret_key;
                init_start_d = 1'b1;
            end
            PH_INIT: if (init_fin_strobe) begin
                state_d     = PH_KSA;
                ksa_start_d = 1'b1;
            end else if (expired) state_d = PH_ERROR;
            PH_KSA: if (ksa_fin_strobe) begin
                state_d      = PH_PRGA;
                prga_start_d = 1'b1;
            end else if (expired) state_d = PH_ERROR;
            PH_PRGA: state_d = prga_fin_strobe ? PH_DONE : expired ? PH_ERROR : PH_PRGA;
            default: state_d = PH_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= PH_IDLE;
            key_q        <= '0;
            init_start_q <= 1'b0;
            ksa_start_q  <= 1'b0;
            prga_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            key_q        <= key_d;
            init_start_q <= init_start_d;
            ksa_start_q  <= ksa_start_d;
            prga_start_q <= prga_start_d;
        end
    end
    // Ownership follows the registered phase so the mux adds no latency
    always_comb begin
        mem_addr  = state_q == PH_INIT ? init_addr  : state_q == PH_KSA ? ksa_addr  : state_q == PH_PRGA ? prga_addr  : '0;
        mem_wdata = state_q == PH_INIT ? init_wdata : state_q == PH_KSA ? ksa_wdata : state_q == PH_PRGA ? prga_wdata : '0;
        mem_wr_en = state_q == PH_INIT ? init_wr_en : state_q == PH_KSA ? ksa_wr_en : state_q == PH_PRGA ? prga_wr_en : 1'b0;
    end
    assign rdata_out   = mem_rdata;
    assign key_out     = key_q;
    assign init_start  = init_start_q;
    assign ksa_start   = ksa_start_q;
    assign prga_start  = prga_start_q;
    assign busy        = state_q == PH_INIT || state_q == PH_KSA || state_q == PH_PRGA;
    assign done_strobe = state_q == PH_DONE;
    assign phase       = state_q;
    assign unused_ok   = ^{init_task_on, ksa_task_on, prga_task_on, TIMEOUT_CYCLES[0]};
`ifdef RC4_SEQ_WATCHDOG_EN
    phase_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (state_d != state_q),
        .enable (busy),
        .expired(expired)
    );
    assign err = state_q == PH_ERROR;
`else
    assign expired = 1'b0;
    assign err     = 1'b0;
`endif
endmodule

// File: tb/tb_rc4_sequencer.sv
// tb_rc4_sequencer: directed checks of phase sequencing, memory ownership, reset and (with RC4_SEQ_WATCHDOG_EN) timeout
module tb_rc4_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [23:0] secret_key = '0;
    logic [7:0] init_addr = '0, init_wdata = '0, ksa_addr = '0, ksa_wdata = '0, prga_addr = '0, prga_wdata = '0;
    logic init_wr_en = 1'b0, ksa_wr_en = 1'b0, prga_wr_en = 1'b0;
    logic init_fin = 1'b0, ksa_fin = 1'b0, prga_fin = 1'b0;
    logic [7:0] mem_rdata = '0;
    logic [23:0] key_out;
    logic init_start, ksa_start, prga_start, mem_wr_en, busy, done_strobe, err;
    logic [7:0] mem_addr, mem_wdata, rdata_out;
    logic [2:0] phase;
    int errors = 0;
    int checks = 0;
    int n_init = 0, n_ksa = 0, n_prga = 0, n_done = 0;

    always #5 clk = ~clk;

    rc4_sequencer #(.TIMEOUT_CYCLES(2048)) dut (
        .clk(clk), .rst(rst), .start(start), .secret_key(secret_key), .key_out(key_out),
        .init_start(init_start), .ksa_start(ksa_start), .prga_start(prga_start),
        .init_addr(init_addr), .init_wdata(init_wdata), .init_wr_en(init_wr_en), .init_task_on(1'b1), .init_fin_strobe(init_fin),
        .ksa_addr(ksa_addr), .ksa_wdata(ksa_wdata), .ksa_wr_en(ksa_wr_en), .ksa_task_on(1'b1), .ksa_fin_strobe(ksa_fin),
        .prga_addr(prga_addr), .prga_wdata(prga_wdata), .prga_wr_en(prga_wr_en), .prga_task_on(1'b1), .prga_fin_strobe(prga_fin),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr_en(mem_wr_en), .mem_rdata(mem_rdata), .rdata_out(rdata_out),
        .busy(busy), .done_strobe(done_strobe), .err(err), .phase(phase)
    );

`ifdef RC4_SEQ_WATCHDOG_EN
    logic [23:0] w_key_out;
    logic w_init_start, w_ksa_start, w_prga_start, w_mem_wr_en, w_busy, w_done, w_err;
    logic [7:0] w_mem_addr, w_mem_wdata, w_rdata_out;
    logic [2:0] w_phase;
    rc4_sequencer #(.TIMEOUT_CYCLES(16)) u_wd (
        .clk(clk), .rst(rst), .start(start), .secret_key(secret_key), .key_out(w_key_out),
        .init_start(w_init_start), .ksa_start(w_ksa_start), .prga_start(w_prga_start),
        .init_addr(init_addr), .init_wdata(init_wdata), .init_wr_en(init_wr_en), .init_task_on(1'b1), .init_fin_strobe(init_fin),
        .ksa_addr(ksa_addr), .ksa_wdata(ksa_wdata), .ksa_wr_en(ksa_wr_en), .ksa_task_on(1'b1), .ksa_fin_strobe(ksa_fin),
        .prga_addr(prga_addr), .prga_wdata(prga_wdata), .prga_wr_en(prga_wr_en), .prga_task_on(1'b1), .prga_fin_strobe(prga_fin),
        .mem_addr(w_mem_addr), .mem_wdata(w_mem_wdata), .mem_wr_en(w_mem_wr_en), .mem_rdata(mem_rdata), .rdata_out(w_rdata_out),
        .busy(w_busy), .done_strobe(w_done), .err(w_err), .phase(w_phase)
    );
`endif

    always @(negedge clk) begin
        n_init += int'(init_start);
        n_ksa  += int'(ksa_start);
        n_prga += int'(prga_start);
        n_done += int'(done_strobe);
        checks++;
        assert ($onehot0({init_start, ksa_start, prga_start})) else begin
            errors++;
            $error("FAIL start_onehot: got %b expected at most one high", {init_start, ksa_start, prga_start});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        step();
        step();
        rst = 1'b0;
        chk("rst_key", 32'(key_out), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_phase", 32'(phase), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_done", 32'(done_strobe), 32'h0);
        chk("rst_starts", 32'({init_start, ksa_start, prga_start}), 32'h0);
        chk("rst_wr_en", 32'(mem_wr_en), 32'h0);
        // idle: requests must not reach memory
        init_wr_en = 1'b1; init_addr = 8'h55; init_wdata = 8'hCC; mem_rdata = 8'h5A;
        #1;
        chk("idle_wr_en", 32'(mem_wr_en), 32'h0);
        chk("idle_addr", 32'(mem_addr), 32'h0);
        chk("idle_wdata", 32'(mem_wdata), 32'h0);
        chk("rdata_out", 32'(rdata_out), 32'h5A);
        // full run
        secret_key = 24'h000249; start = 1'b1;
        step();
        start = 1'b0;
        chk("init_phase", 32'(phase), 32'h1);
        chk("init_start", 32'(init_start), 32'h1);
        chk("key_latched", 32'(key_out), 32'h000249);
        chk("init_busy", 32'(busy), 32'h1);
        chk("init_addr_mux", 32'(mem_addr), 32'h55);
        step();
        chk("init_start_width", 32'(init_start), 32'h0);
        repeat (254) step();
        init_fin = 1'b1;
        step();
        init_fin = 1'b0;
        chk("ksa_phase", 32'(phase), 32'h2);
        chk("ksa_start", 32'(ksa_start), 32'h1);
        step();
        chk("ksa_start_width", 32'(ksa_start), 32'h0);
        ksa_addr = 8'h10; ksa_wdata = 8'hAB; ksa_wr_en = 1'b1;
        #1;
        chk("ksa_addr_mux", 32'(mem_addr), 32'h10);
        chk("ksa_wdata_mux", 32'(mem_wdata), 32'hAB);
        chk("ksa_wr_en_mux", 32'(mem_wr_en), 32'h1);
        ksa_wr_en = 1'b0;
        #1;
        chk("init_wr_blocked", 32'(mem_wr_en), 32'h0);
        init_fin = 1'b1;
        step();
        init_fin = 1'b0;
        chk("foreign_fin_ignored", 32'(phase), 32'h2);
        secret_key = 24'hFFFFFF; start = 1'b1;
        step();
        start = 1'b0;
        chk("busy_start_key", 32'(key_out), 32'h000249);
        chk("busy_start_phase", 32'(phase), 32'h2);
        chk("busy_start_no_init", 32'(init_start), 32'h0);
        repeat (764) step();
        ksa_fin = 1'b1;
        step();
        ksa_fin = 1'b0;
        chk("prga_phase", 32'(phase), 32'h3);
        chk("prga_start", 32'(prga_start), 32'h1);
        prga_addr = 8'h77; prga_wdata = 8'h11; prga_wr_en = 1'b1;
        #1;
        chk("prga_addr_mux", 32'(mem_addr), 32'h77);
        chk("prga_wr_en_mux", 32'(mem_wr_en), 32'h1);
        prga_wr_en = 1'b0;
        repeat (511) step();
        prga_fin = 1'b1;
        step();
        prga_fin = 1'b0;
        chk("done_strobe", 32'(done_strobe), 32'h1);
        chk("done_phase", 32'(phase), 32'h4);
        chk("done_busy", 32'(busy), 32'h0);
        chk("done_wr_en", 32'(mem_wr_en), 32'h0);
        step();
        chk("done_width", 32'(done_strobe), 32'h0);
        chk("back_idle", 32'(phase), 32'h0);
        chk("idle_busy", 32'(busy), 32'h0);
        chk("n_init", 32'(n_init), 32'h1);
        chk("n_ksa", 32'(n_ksa), 32'h1);
        chk("n_prga", 32'(n_prga), 32'h1);
        chk("n_done", 32'(n_done), 32'h1);
        chk("run_err", 32'(err), 32'h0);
        // reset mid-PRGA
        secret_key = 24'h000249; start = 1'b1;
        step();
        start = 1'b0; init_fin = 1'b1;
        step();
        init_fin = 1'b0; ksa_fin = 1'b1;
        step();
        ksa_fin = 1'b0;
        chk("fast_prga", 32'(phase), 32'h3);
        prga_wr_en = 1'b1;
        #1;
        chk("fast_prga_wr", 32'(mem_wr_en), 32'h1);
        rst = 1'b1; prga_fin = 1'b1;
        step();
        rst = 1'b0; prga_fin = 1'b0;
        chk("midrst_phase", 32'(phase), 32'h0);
        chk("midrst_wr_en", 32'(mem_wr_en), 32'h0);
        chk("midrst_done", 32'(done_strobe), 32'h0);
        chk("midrst_key", 32'(key_out), 32'h0);
        step();
        chk("midrst_done_after", 32'(done_strobe), 32'h0);
        chk("midrst_n_done", 32'(n_done), 32'h1);
        prga_wr_en = 1'b0; init_wr_en = 1'b0;
`ifdef RC4_SEQ_WATCHDOG_EN
        rst = 1'b1;
        step();
        rst = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0; init_fin = 1'b1;
        step();
        init_fin = 1'b0;
        chk("wd_ksa", 32'(w_phase), 32'h2);
        repeat (15) step();
        chk("wd_ksa_last", 32'(w_phase), 32'h2);
        chk("wd_err_low", 32'(w_err), 32'h0);
        step();
        chk("wd_error_phase", 32'(w_phase), 32'h5);
        chk("wd_err", 32'(w_err), 32'h1);
        chk("wd_err_busy", 32'(w_busy), 32'h0);
        step();
        chk("wd_err_hold", 32'(w_err), 32'h1);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("wd_err_clear", 32'(w_err), 32'h0);
        chk("wd_restart", 32'(w_phase), 32'h1);
        chk("wd_restart_pulse", 32'(w_init_start), 32'h1);
        repeat (15) step();
        init_fin = 1'b1;
        step();
        init_fin = 1'b0;
        chk("wd_fin_wins", 32'(w_phase), 32'h2);
        chk("wd_fin_err", 32'(w_err), 32'h0);
        chk("wd_fin_ksa_start", 32'(w_ksa_start), 32'h1);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
